// File: rtl/fetch_queue_if.sv
// Fetch/decode bus for fetch_queue: two-word enqueue from fetch, two-word valid/ready dequeue to decode, flush.
// FQ_PC_TAG_EN adds the flush restart PC and the per-slot output PCs.
interface fetch_queue_if;

   logic [1:0][31:0] i_insts;
   logic [1:0]       i_valid;
   logic             o_ready;
   logic [1:0][31:0] o_insts;
   logic [1:0]       o_valid;
   logic             i_dec_ready;
   logic             i_flush;
`ifdef FQ_PC_TAG_EN
   logic [31:0]      i_flush_pc;
   logic [1:0][31:0] o_pcs;
`endif

`ifdef FQ_PC_TAG_EN
   modport master (
      output i_insts, i_valid, i_dec_ready, i_flush, i_flush_pc,
      input  o_ready, o_insts, o_valid, o_pcs
   );

   modport slave (
      input  i_insts, i_valid, i_dec_ready, i_flush, i_flush_pc,
      output o_ready, o_insts, o_valid, o_pcs
   );
`else
   modport master (
      output i_insts, i_valid, i_dec_ready, i_flush,
      input  o_ready, o_insts, o_valid
   );

   modport slave (
      input  i_insts, i_valid, i_dec_ready, i_flush,
      output o_ready, o_insts, o_valid
   );
`endif

endinterface

// File: rtl/fetch_queue.sv
// Circular decoupling buffer between the dual-issue fetch stage and decode; drops all-zero words.
// Optional macro FQ_PC_TAG_EN stores a PC alongside every queued word.
module fetch_queue #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic          i_clk,
   input logic          i_rst,
   fetch_queue_if.slave fq
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

`ifdef FQ_PC_TAG_EN
   localparam int EW = 64;
`else
   localparam int EW = 32;
`endif

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two and at least 4");
   end
   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("fetch_queue: RESET_PC must be word aligned");
   end

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;
   logic [EW-1:0] mem [DEPTH];

   logic          ready;
   logic [1:0]    accept;
   logic [1:0]    enq_cnt;
   logic [1:0]    out_valid;
   logic [1:0]    deq_cnt;
   logic [AW-1:0] wr_idx1;
   logic [AW-1:0] rd_idx1;
   logic [EW-1:0] wr_data0;
   logic [EW-1:0] wr_data1;
   logic [EW-1:0] rd_data0;
   logic [EW-1:0] rd_data1;

`ifdef FQ_PC_TAG_EN
   logic [31:0]   pc_next;
`endif

   // Ready is judged on the registered count alone, so a pair can always land
   // even when decode takes nothing this cycle.
   always_comb begin
      ready     = (count <= CW'(DEPTH - 2));
      accept    = 2'b00;
      accept[0] = ready && fq.i_valid[0] && (fq.i_insts[0] != 32'd0);
      accept[1] = ready && fq.i_valid[1] && (fq.i_insts[1] != 32'd0);
      enq_cnt   = {1'b0, accept[0]} + {1'b0, accept[1]};

      out_valid    = 2'b00;
      out_valid[0] = (count >= CW'(1));
      out_valid[1] = (count >= CW'(2));
      deq_cnt      = fq.i_dec_ready ? ({1'b0, out_valid[0]} + {1'b0, out_valid[1]}) : 2'b00;

      wr_idx1 = tail + AW'(accept[0]);
      rd_idx1 = head + AW'(1);

`ifdef FQ_PC_TAG_EN
      wr_data0 = {pc_next, fq.i_insts[0]};
      wr_data1 = {pc_next + (accept[0] ? 32'd4 : 32'd0), fq.i_insts[1]};
`else
      wr_data0 = fq.i_insts[0];
      wr_data1 = fq.i_insts[1];
`endif
   end

   // Pointer and occupancy state; reset beats flush, flush beats enqueue/dequeue.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (fq.i_flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(deq_cnt);
         tail  <= tail + AW'(enq_cnt);
         count <= count + CW'(enq_cnt) - CW'(deq_cnt);
      end
   end

   // Live words are compacted: a lone slot-1 word lands at tail, not tail+1.
   always_ff @(posedge i_clk) begin
      if (!i_rst && !fq.i_flush) begin
         if (accept[0]) begin
            mem[tail] <= wr_data0;
         end
         if (accept[1]) begin
            mem[wr_idx1] <= wr_data1;
         end
      end
   end

`ifdef FQ_PC_TAG_EN
   // Dropped zero words do not consume a PC.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pc_next <= RESET_PC;
      end else if (fq.i_flush) begin
         pc_next <= fq.i_flush_pc;
      end else begin
         pc_next <= pc_next + {28'd0, enq_cnt, 2'b00};
      end
   end
`endif

   assign rd_data0 = mem[head];
   assign rd_data1 = mem[rd_idx1];

   assign fq.o_ready    = ready;
   assign fq.o_valid    = out_valid;
   assign fq.o_insts[0] = out_valid[0] ? rd_data0[31:0] : 32'd0;
   assign fq.o_insts[1] = out_valid[1] ? rd_data1[31:0] : 32'd0;

`ifdef FQ_PC_TAG_EN
   assign fq.o_pcs[0] = out_valid[0] ? rd_data0[63:32] : 32'd0;
   assign fq.o_pcs[1] = out_valid[1] ? rd_data1[63:32] : 32'd0;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         assert (count <= CW'(DEPTH));
         assert ((accept == 2'b00) || ready);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=8); PC tags are checked when FQ_PC_TAG_EN is defined.
module tb_fetch_queue;

   localparam logic [31:0] INS_A    = 32'h0050_0093;
   localparam logic [31:0] INS_B    = 32'h0010_0113;
   localparam logic [31:0] INS_C    = 32'h0020_8193;
   localparam logic [31:0] INS_D    = 32'h0030_8213;
   localparam logic [31:0] INS_E    = 32'h0040_8293;
   localparam logic [31:0] INS_F    = 32'h0050_8313;
   localparam logic [31:0] INS_G    = 32'h0060_8393;
   localparam logic [31:0] INS_H    = 32'h0070_8413;
   localparam logic [31:0] INS_I    = 32'h0090_0493;
   localparam logic [31:0] INS_J    = 32'h00a0_0513;
   localparam logic [31:0] INS_K    = 32'h00b0_0593;
   localparam logic [31:0] INS_L    = 32'h00c0_0613;
   localparam logic [31:0] INS_M    = 32'h00d0_0693;
   localparam logic [31:0] INS_N    = 32'h00e0_0713;
   localparam logic [31:0] INS_P    = 32'h00f0_0793;
   localparam logic [31:0] INS_Q    = 32'h0100_0813;
   localparam logic [31:0] INS_X1   = 32'hbad0_0001;
   localparam logic [31:0] INS_X2   = 32'hbad0_0002;
   localparam logic [31:0] INS_JUNK = 32'h0ead_beef;
   localparam logic [31:0] FLUSH_PC = 32'h0000_1000;
   localparam int          NUM_VEC  = 21;

   typedef struct {
      logic [1:0]  valid;
      logic [31:0] in0;
      logic [31:0] in1;
      logic        dec;
      logic        flush;
      logic        exp_ready;
      logic [1:0]  exp_valid;
      logic [31:0] exp0;
      logic [31:0] exp1;
      logic [31:0] exp_pc0;
      logic [31:0] exp_pc1;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   vec_t vecs [NUM_VEC];

   fetch_queue_if fq_bus ();

   fetch_queue #(
      .DEPTH    (8),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .fq    (fq_bus)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input logic [1:0] valid, input logic [31:0] in0,
                                input logic [31:0] in1, input logic dec, input logic flush);
      fq_bus.i_valid     = valid;
      fq_bus.i_insts[0]  = in0;
      fq_bus.i_insts[1]  = in1;
      fq_bus.i_dec_ready = dec;
      fq_bus.i_flush     = flush;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic checkPorts(input string tag, input logic exp_ready, input logic [1:0] exp_valid,
                             input logic [31:0] exp0, input logic [31:0] exp1,
                             input logic [31:0] exp_pc0, input logic [31:0] exp_pc1);
      checkOutput({tag, ".o_ready"},    {31'd0, fq_bus.o_ready}, {31'd0, exp_ready});
      checkOutput({tag, ".o_valid"},    {30'd0, fq_bus.o_valid}, {30'd0, exp_valid});
      checkOutput({tag, ".o_insts[0]"}, fq_bus.o_insts[0], exp0);
      checkOutput({tag, ".o_insts[1]"}, fq_bus.o_insts[1], exp1);
`ifdef FQ_PC_TAG_EN
      checkOutput({tag, ".o_pcs[0]"}, fq_bus.o_pcs[0], exp_pc0);
      checkOutput({tag, ".o_pcs[1]"}, fq_bus.o_pcs[1], exp_pc1);
`else
      if (exp_pc0 === 32'hffff_ffff && exp_pc1 === 32'hffff_ffff) begin
         $display("[TB] note %s: unexpected PC sentinel", tag);
      end
`endif
   endtask

   // Main sequence: reset, table of vectors, then reset-with-flush mid-stream.
   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      applyStimulus(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
`ifdef FQ_PC_TAG_EN
      fq_bus.i_flush_pc = FLUSH_PC;
`endif

      //           valid  in0       in1       dec   flush  rdy   vld    exp0     exp1     pc0           pc1
      vecs[0]  = '{2'b11, INS_A,    INS_B,    1'b0, 1'b0,  1'b1, 2'b11, INS_A,   INS_B,   32'd0,        32'd4};
      vecs[1]  = '{2'b11, INS_C,    INS_D,    1'b0, 1'b0,  1'b1, 2'b11, INS_A,   INS_B,   32'd0,        32'd4};
      vecs[2]  = '{2'b11, INS_E,    INS_F,    1'b0, 1'b0,  1'b1, 2'b11, INS_A,   INS_B,   32'd0,        32'd4};
      vecs[3]  = '{2'b11, INS_G,    INS_H,    1'b0, 1'b0,  1'b0, 2'b11, INS_A,   INS_B,   32'd0,        32'd4};
      vecs[4]  = '{2'b11, INS_X1,   INS_X2,   1'b0, 1'b0,  1'b0, 2'b11, INS_A,   INS_B,   32'd0,        32'd4};
      vecs[5]  = '{2'b00, 32'd0,    32'd0,    1'b1, 1'b0,  1'b1, 2'b11, INS_C,   INS_D,   32'd8,        32'd12};
      vecs[6]  = '{2'b00, 32'd0,    32'd0,    1'b1, 1'b0,  1'b1, 2'b11, INS_E,   INS_F,   32'd16,       32'd20};
      vecs[7]  = '{2'b00, 32'd0,    32'd0,    1'b1, 1'b0,  1'b1, 2'b11, INS_G,   INS_H,   32'd24,       32'd28};
      vecs[8]  = '{2'b11, 32'd0,    INS_C,    1'b0, 1'b0,  1'b1, 2'b11, INS_G,   INS_H,   32'd24,       32'd28};
      vecs[9]  = '{2'b00, 32'd0,    32'd0,    1'b1, 1'b0,  1'b1, 2'b01, INS_C,   32'd0,   32'd32,       32'd0};
      vecs[10] = '{2'b11, INS_I,    INS_J,    1'b0, 1'b0,  1'b1, 2'b11, INS_C,   INS_I,   32'd32,       32'd36};
      vecs[11] = '{2'b11, INS_K,    INS_L,    1'b1, 1'b0,  1'b1, 2'b11, INS_J,   INS_K,   32'd40,       32'd44};
      vecs[12] = '{2'b11, INS_M,    INS_N,    1'b1, 1'b0,  1'b1, 2'b11, INS_L,   INS_M,   32'd48,       32'd52};
      vecs[13] = '{2'b00, 32'd0,    32'd0,    1'b1, 1'b0,  1'b1, 2'b01, INS_N,   32'd0,   32'd56,       32'd0};
      vecs[14] = '{2'b11, INS_P,    INS_Q,    1'b1, 1'b0,  1'b1, 2'b11, INS_P,   INS_Q,   32'd60,       32'd64};
      vecs[15] = '{2'b00, 32'd0,    32'd0,    1'b1, 1'b0,  1'b1, 2'b00, 32'd0,   32'd0,   32'd0,        32'd0};
      vecs[16] = '{2'b11, INS_A,    INS_B,    1'b0, 1'b0,  1'b1, 2'b11, INS_A,   INS_B,   32'd68,       32'd72};
      vecs[17] = '{2'b11, INS_C,    INS_D,    1'b0, 1'b0,  1'b1, 2'b11, INS_A,   INS_B,   32'd68,       32'd72};
      vecs[18] = '{2'b01, INS_E,    INS_JUNK, 1'b0, 1'b0,  1'b1, 2'b11, INS_A,   INS_B,   32'd68,       32'd72};
      vecs[19] = '{2'b11, INS_F,    INS_G,    1'b1, 1'b1,  1'b1, 2'b00, 32'd0,   32'd0,   32'd0,        32'd0};
      vecs[20] = '{2'b11, INS_H,    INS_I,    1'b0, 1'b0,  1'b1, 2'b11, INS_H,   INS_I,   FLUSH_PC,     FLUSH_PC + 32'd4};

      repeat (2) @(posedge clk);
      #1;
      checkPorts("reset", 1'b1, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < NUM_VEC; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].in0, vecs[i].in1, vecs[i].dec, vecs[i].flush);
         if (i == 0) begin
            #1;
            checkOutput("no_bypass.o_valid", {30'd0, fq_bus.o_valid}, 32'd0);
         end
         @(posedge clk);
         #1;
         checkPorts($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
                    vecs[i].exp0, vecs[i].exp1, vecs[i].exp_pc0, vecs[i].exp_pc1);
      end

      // Fill to four entries, then hit reset together with flush and traffic.
      applyStimulus(2'b11, INS_C, INS_D, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkPorts("prefill", 1'b1, 2'b11, INS_H, INS_I, FLUSH_PC, FLUSH_PC + 32'd4);

      rst = 1'b1;
      applyStimulus(2'b11, INS_E, INS_F, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      checkPorts("rst_over_flush", 1'b1, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
      rst = 1'b0;

      // Zero word in slot 0 is dropped; the survivor takes the reset PC.
      applyStimulus(2'b11, 32'd0, INS_C, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      checkPorts("drop_zero", 1'b1, 2'b01, INS_C, 32'd0, 32'd0, 32'd0);

      applyStimulus(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      checkPorts("drain", 1'b1, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
